// File: rtl/button_pio_pkg.sv
// Shared register map and edge-type encodings for the button PIO.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  // True when a transition to new_level counts as a capturable edge.
  function automatic logic edge_match(input logic [1:0] edge_type, input logic new_level);
    case (edge_type)
      EDGE_RISING:  edge_match = new_level;
      EDGE_FALLING: edge_match = ~new_level;
      default:      edge_match = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/button_pio_irq_if.sv
// Avalon-MM slave bus plus interrupt line for the button PIO.
interface button_pio_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchroniser, hold-time debounce, stable level and edge pulse.
module pio_debounce_bit
  import button_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable,
  output logic edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  // Accept the new level on the edge the counter sits at its terminal value.
  assign accept     = (sync2 != stable) && (cnt == TERM);
  assign edge_pulse = accept && edge_match(2'(EDGE_TYPE), sync2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_BIT;
      sync2  <= RESET_BIT;
      stable <= RESET_BIT;
      cnt    <= '0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_pio_irq.sv
// Multi-bit debounced input PIO with edge capture and maskable level irq,
// standard PIO register map (data, direction, irqmask, edgecapture).
module button_pio_irq
  import button_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  button_pio_irq_if.slave  bus,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE),
      .RESET_BIT       (RESET_LEVEL[i])
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_bit     (in_port[i]),
      .stable     (stable[i]),
      .edge_pulse (edge_vec[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end

  assign wr       = bus.chipselect && !bus.write_n;
  assign clr_mask = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_DIR:     rd_mux = '0;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear so a colliding set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask      <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
    end else begin
      edgecap      <= (edgecap & ~clr_mask) | edge_vec;
      bus.readdata <= rd_mux;
      if (wr && bus.address == ADDR_IRQMASK)
        irqmask <= bus.writedata[WIDTH-1:0];
    end
  end

  assign bus.irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_button_pio_irq.sv
// Bench for button_pio_irq: two instances (falling-edge and any-edge) checked
// every cycle against a window-based debounce model, plus directed literal checks.
module tb_button_pio_irq;
  import button_pio_pkg::*;

  localparam int W = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  button_pio_irq_if bus_a ();
  button_pio_irq_if bus_b ();

  logic [W-1:0] in_a, in_b;
  logic [1:0]   addr [2];
  logic         cs   [2];
  logic         wn   [2];
  logic [31:0]  wd   [2];
  logic [31:0]  rd_dut [2];
  logic         irq_dut[2];

  assign bus_a.address = addr[0]; assign bus_a.chipselect = cs[0];
  assign bus_a.write_n = wn[0];   assign bus_a.writedata  = wd[0];
  assign bus_b.address = addr[1]; assign bus_b.chipselect = cs[1];
  assign bus_b.write_n = wn[1];   assign bus_b.writedata  = wd[1];
  assign rd_dut[0] = bus_a.readdata; assign irq_dut[0] = bus_a.irq;
  assign rd_dut[1] = bus_b.readdata; assign irq_dut[1] = bus_b.irq;

  button_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .RESET_LEVEL(4'hF)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a));
  button_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .RESET_LEVEL(4'hF)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b));

  int checks = 0;
  int fails  = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // samp[d][0] is the input seen at the previous edge; a bit's level is accepted
  // once the D synchronised samples (delayed two edges) all disagree with it.
  logic [W-1:0] samp [2][D+1];
  logic [W-1:0] m_stab[2], m_ec[2], m_mask[2];
  logic [31:0]  m_rd[2];
  logic [W-1:0] n_stab, n_edge, n_clr, cur_in;
  bit           all_diff;

  function automatic bit edge_ok(input int d, input logic lvl);
    if (d == 0) return !lvl;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        for (int k = 0; k <= D; k++) samp[d][k] = 4'hF;
        m_stab[d] = 4'hF; m_ec[d] = '0; m_mask[d] = '0; m_rd[d] = '0;
      end else begin
        cur_in = (d == 0) ? in_a : in_b;
        case (addr[d])
          2'd0:    m_rd[d] = {28'd0, m_stab[d]};
          2'd2:    m_rd[d] = {28'd0, m_mask[d]};
          2'd3:    m_rd[d] = {28'd0, m_ec[d]};
          default: m_rd[d] = 32'd0;
        endcase
        n_stab = m_stab[d];
        n_edge = '0;
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= D; k++)
            if (samp[d][k][i] == m_stab[d][i]) all_diff = 1'b0;
          if (all_diff) begin
            n_stab[i] = ~m_stab[d][i];
            n_edge[i] = edge_ok(d, n_stab[i]);
          end
        end
        n_clr = (cs[d] && !wn[d] && addr[d] == 2'd3) ? wd[d][W-1:0] : '0;
        m_ec[d] = (m_ec[d] & ~n_clr) | n_edge;
        if (cs[d] && !wn[d] && addr[d] == 2'd2) m_mask[d] = wd[d][W-1:0];
        m_stab[d] = n_stab;
        for (int k = D; k >= 1; k--) samp[d][k] = samp[d][k-1];
        samp[d][0] = cur_in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_rd%0d", d), rd_dut[d], m_rd[d]);
        chk($sformatf("model_irq%0d", d), {31'd0, irq_dut[d]}, {31'd0, |(m_ec[d] & m_mask[d])});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    cs[d] = 1'b0; wn[d] = 1'b1; wd[d] = '0;
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    cs[d] = 1'b1; wn[d] = 1'b0; addr[d] = a; wd[d] = v;
    tick();
    idle(d);
  endtask

  initial begin
    in_a = 4'hF; in_b = 4'hF;
    for (int d = 0; d < 2; d++) begin addr[d] = 2'd0; idle(d); end
    reset_n = 1'b0;
    tick();
    chk_on = 1;
    repeat (2) tick();
    reset_n = 1'b1;

    // reset register reads, one clock after the address
    for (int a = 0; a < 4; a++) begin
      addr[0] = 2'(a);
      tick();
      chk($sformatf("rst_read_a%0d", a), rd_dut[0], (a == 0) ? 32'hF : 32'h0);
    end

    // press bit 0 (falling edge): stable updates on edge D+2, seen on readdata one later
    addr[0] = 2'd0;
    in_a[0] = 1'b0;
    repeat (D + 2) tick();
    chk("lat_before", rd_dut[0], 32'hF);
    tick();
    chk("lat_data", rd_dut[0], 32'hE);
    addr[0] = 2'd3;
    tick();
    chk("edgecap_b0", rd_dut[0], 32'h1);
    chk("irq_masked", {31'd0, irq_dut[0]}, 32'h0);
    wr(0, 2'd2, 32'h1);
    chk("irq_unmask", {31'd0, irq_dut[0]}, 32'h1);

    // 7-cycle glitch on bit 1 must be ignored
    in_a[1] = 1'b0;
    repeat (D - 1) tick();
    in_a[1] = 1'b1;
    repeat (15) tick();
    addr[0] = 2'd0; tick();
    chk("glitch_data", rd_dut[0], 32'hE);
    addr[0] = 2'd3; tick();
    chk("glitch_ecap", rd_dut[0], 32'h1);

    // full press after the glitch takes the full latency again (counter cleared)
    addr[0] = 2'd0;
    in_a[1] = 1'b0;
    repeat (D + 2) tick();
    chk("b1_before", rd_dut[0], 32'hE);
    tick();
    chk("b1_data", rd_dut[0], 32'hC);
    addr[0] = 2'd3; tick();
    chk("ecap_3", rd_dut[0], 32'h3);
    wr(0, 2'd3, 32'h1);
    tick();
    chk("w1c_b0", rd_dut[0], 32'h2);
    chk("irq_b1_masked", {31'd0, irq_dut[0]}, 32'h0);
    wr(0, 2'd2, 32'h3);
    chk("irq_b1_unmask", {31'd0, irq_dut[0]}, 32'h1);

    // clear colliding with a new edge: set wins
    in_a[1] = 1'b1;
    repeat (D + 4) tick();
    wr(0, 2'd3, 32'h2);
    tick();
    chk("ecap_cleared", rd_dut[0], 32'h0);
    in_a[1] = 1'b0;
    repeat (D + 1) tick();
    wr(0, 2'd3, 32'h2);
    tick();
    chk("set_wins", rd_dut[0], 32'h2);

    // any-edge instance: press and release both capture
    addr[1] = 2'd3;
    in_b[2] = 1'b0;
    repeat (D + 3) tick();
    chk("any_press", rd_dut[1], 32'h4);
    wr(1, 2'd3, 32'h4);
    tick();
    chk("any_clear", rd_dut[1], 32'h0);
    in_b[2] = 1'b1;
    repeat (D + 3) tick();
    chk("any_release", rd_dut[1], 32'h4);

    // reset mid-debounce: outputs drop immediately, stable back to reset level
    in_a[3] = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_a", rd_dut[0], 32'h0);
    chk("mid_rst_irq_a", {31'd0, irq_dut[0]}, 32'h0);
    chk("mid_rst_rd_b", rd_dut[1], 32'h0);
    in_a = 4'hF;
    repeat (2) tick();
    reset_n = 1'b1;
    addr[0] = 2'd0; tick();
    chk("post_rst_data", rd_dut[0], 32'hF);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) in_a[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) in_b[$urandom_range(0, W-1)] ^= 1'b1;
      for (int d = 0; d < 2; d++) begin
        addr[d] = 2'($urandom_range(0, 3));
        cs[d]   = ($urandom_range(0, 3) == 0);
        wn[d]   = ($urandom_range(0, 1) == 0);
        wd[d]   = $urandom;
      end
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      tick();
    end
    for (int d = 0; d < 2; d++) idle(d);
    repeat (3) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/button_pio_irq.md
# button_pio_irq

Parametrised Avalon-MM input PIO for push-buttons and switches with per-bit synchronisation, debounce, edge capture and a maskable level interrupt. Sits on the Nios II data master as a peripheral slave, with in_port wired to board buttons. It is the multi-bit, interrupt-capable successor to the single-bit read-only button port, and keeps the standard PIO register map so existing HAL drivers apply.

## Interface
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, clk cycles an input must hold a new level before it is accepted (>=1)
- EDGE_TYPE, 1, edge that sets edgecapture: 0 rising, 1 falling, 2 any
- RESET_LEVEL, all ones (WIDTH bits), reset value of synchroniser and stable registers (buttons idle high)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  raw asynchronous inputs
- irq  out  1  level interrupt, active high

## Operation
- Per bit: a 2-flop synchroniser feeds a debounce counter and a stable register.
  - If sync != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != stable, stable <= sync and the counter clears.
  - If sync == stable, the counter clears. A glitch shorter than DEBOUNCE_CYCLES is therefore ignored.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). There is no wrap-around, because the counter clears at its terminal value.
- An edge is a stable-register transition matching EDGE_TYPE. The edge sets edgecapture[i] on the same clock edge that stable[i] updates.
- Register map (bits above WIDTH read 0):
  - 0 data: RO, stable[WIDTH-1:0]; writes ignored.
  - 1 direction: reads 0, writes ignored.
  - 2 irqmask: RW, WIDTH bits.
  - 3 edgecapture: read returns captured bits. A write with chipselect=1, write_n=0 clears each bit where writedata[i]=1 (write-1-to-clear).
- Simultaneous clear and new edge on the same bit: set wins, so the bit stays 1.
- irq = |(edgecapture & irqmask), driven combinationally from registers, so it is glitch-free.
- readdata <= mux(address) every clk regardless of chipselect. Reads have no side effects.

## Timing
- Reset values:
  - readdata 0, irqmask 0, edgecapture 0, irq 0.
  - Counters 0.
  - sync and stable at RESET_LEVEL.
- Read latency is 1 clk: readdata is valid on the edge after address is presented. No waitrequest.
- Write takes effect on the clk edge where chipselect=1 and write_n=0. irq reflects an irqmask or edgecapture write on the next cycle.
- Input-to-stable latency is DEBOUNCE_CYCLES+2 clk edges after an in_port change.
  - edgecapture sets on that same edge.
  - irq rises on that same edge, if the bit is unmasked.
- Reset asserted mid-debounce or mid-capture: all state returns to reset values immediately. Edges in flight are lost.
- An input held at a level other than RESET_LEVEL through reset release produces one edge after DEBOUNCE_CYCLES+2 cycles. Software clears edgecapture at init.

## Structure
- Shared package button_pio_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- Sub-module pio_debounce_bit (synchroniser, counter, stable register, edge pulse output) is instantiated WIDTH times in a generate loop.
- The top level holds the register file, the read mux and the irq reduction.

## Test plan
- Reset, then read each address -> readdata 0 at addresses 1, 2 and 3. Address 0 reads RESET_LEVEL (0xF for WIDTH=4), each valid exactly 1 clk after address.
- DEBOUNCE_CYCLES=8, EDGE_TYPE=1: drive in_port[0] low and hold. Expect:
  - data[0]=0 and edgecapture=0x1 exactly 10 clks after the change;
  - irq stays 0 while irqmask=0, and irq=1 the cycle after writing irqmask=0x1.
- Pulse in_port[1] low for 7 clks with DEBOUNCE_CYCLES=8 -> no change to data or edgecapture, and the counter returns to 0.
- edgecapture=0x3, write 0x1 to address 3 -> edgecapture=0x2 and irq follows the mask. A write of 0x2 on the same cycle that a new bit-1 edge lands -> bit 1 stays 1.
- EDGE_TYPE=2: press and release in_port[2] -> edgecapture[2] set on the press and again on the release after clearing between them. Reset_n asserted mid-debounce -> all outputs 0 and stable=RESET_LEVEL immediately.
